// File: rtl/shader_spi_loader.sv
`timescale 1ns/1ps
// shader_spi_loader: SPI mode-0 slave that writes and reads back the shader instruction memory.
// Latency: mem_we 1 clk after the synchronized 8th rise; read data reaches tx 2 clk after the fetch.
// Backpressure: none; the SPI master paces everything and busy stalls shader execution meanwhile.
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   spi_cs/sclk/mosi (in)    raw SPI pins, asynchronous to clk; spi_miso (out) serial read data
//   mem_addr/wdata/we (out)  memory address, write data, one-clk write strobe
//   mem_rdata (in)           memory read data, valid 1 clk after mem_addr changes
//   busy (out)               high while a frame is being decoded
module shader_spi_loader #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int MEM_DEPTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } state_t;

  state_t state_q, state_d;

  // Synchronizers; cs resets high so a released reset never looks like a frame start.
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] tx_q;
  logic              rd_mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        fetch_q;   // bit0: address presented, bit1: mem_rdata valid
  logic              miso_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;

  logic              cs_s, sclk_s, mosi_s;
  logic              sclk_rise, sclk_fall, cs_fall, byte_done;
  logic [DATA_W-1:0] rx_byte;
  logic [ADDR_W-1:0] addr_next;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // Gated by cs so a deselect coinciding with the 8th rise never completes a byte.
  assign byte_done = sclk_rise && !cs_s && (state_q != ST_IDLE) &&
                     (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign rx_byte   = {rx_q[DATA_W-2:0], mosi_s};
  assign addr_next = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;

  assign spi_miso  = miso_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if (rx_byte == DATA_W'(8'h02) || rx_byte == DATA_W'(8'h03)) begin
              state_d = ST_ADDR;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: if (byte_done) state_d = rd_mode_q ? ST_READ : ST_WRITE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_mode_q   <= 1'b0;
      addr_q      <= '0;
      fetch_q     <= '0;
      miso_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      mem_we_q    <= 1'b0;
      fetch_q     <= {fetch_q[0], 1'b0};

      if (cs_s) begin
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
        fetch_q   <= '0;
      end else if (state_q != ST_IDLE) begin
        if (sclk_rise) begin
          bit_cnt_q <= byte_done ? '0 : bit_cnt_q + 1'b1;
          rx_q      <= rx_byte;
        end

        if (byte_done) begin
          case (state_q)
            ST_CMD: rd_mode_q <= (rx_byte == DATA_W'(8'h03));
            ST_ADDR: begin
              addr_q <= rx_byte[ADDR_W-1:0];
              if (rd_mode_q) begin
                mem_addr_q <= rx_byte[ADDR_W-1:0];
                fetch_q    <= 2'b01;
              end
            end
            ST_WRITE: begin
              mem_addr_q  <= addr_q;
              mem_wdata_q <= rx_byte;
              mem_we_q    <= 1'b1;
              addr_q      <= addr_next;
            end
            ST_READ: begin
              addr_q     <= addr_next;
              mem_addr_q <= addr_next;
              fetch_q    <= 2'b01;
            end
            default: ;
          endcase
        end

        if (sclk_fall && state_q == ST_READ) begin
          miso_q <= tx_q[DATA_W-1];
          tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
        end

        // Fetched word overrides any shift; it lands well before the next fall.
        if (fetch_q[1]) begin
          tx_q <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_shader_spi_loader.sv
`timescale 1ns/1ps
module tb_shader_spi_loader;

  localparam int HALF = 40;  // sclk half-period: f_sclk = f_clk/8

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_cs, spi_sclk, spi_mosi;
  logic       spi_miso;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       busy;

  shader_spi_loader dut (
    .clk      (clk),
    .rst      (rst),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory model plus a log of every write strobe.
  logic [7:0] mem [16];
  logic [3:0] wa  [64];
  logic [7:0] wd  [64];
  int         we_cnt = 0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      mem[mem_addr]   <= mem_wdata;
      wa[6'(we_cnt)]  <= mem_addr;
      wd[6'(we_cnt)]  <= mem_wdata;
      we_cnt          <= we_cnt + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      #HALF;
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      #HALF;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    @(posedge clk);
    #(2 + $urandom_range(0, 7));
    spi_cs = 1'b0;
    #HALF;
  endtask

  task automatic frame_end();
    #HALF;
    spi_cs = 1'b1;
    repeat (8) @(posedge clk);
    #2;
  endtask

  logic [7:0] rxb;
  logic [7:0] pat [16];
  int         base;

  initial begin
    rst = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    #1 rst = 1'b1;
    #20;
    chk("rst_miso", 32'(spi_miso), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Write 02 05 A5 3C
    base = we_cnt;
    frame_start();
    spi_bits(8'h02, 8, rxb);
    chk("wr_busy", 32'(busy), 1);
    spi_bits(8'h05, 8, rxb);
    spi_bits(8'hA5, 8, rxb);
    spi_bits(8'h3C, 8, rxb);
    frame_end();
    chk("wr_cnt", we_cnt - base, 2);
    chk("wr0_addr", 32'(wa[6'(base)]), 'h5);
    chk("wr0_data", 32'(wd[6'(base)]), 'hA5);
    chk("wr1_addr", 32'(wa[6'(base + 1)]), 'h6);
    chk("wr1_data", 32'(wd[6'(base + 1)]), 'h3C);
    chk("wr_busy_end", 32'(busy), 0);

    // Preload 14,15,0 through a wrapping write burst
    base = we_cnt;
    frame_start();
    spi_bits(8'h02, 8, rxb);
    spi_bits(8'h0E, 8, rxb);
    spi_bits(8'h81, 8, rxb);
    spi_bits(8'h7E, 8, rxb);
    spi_bits(8'hFF, 8, rxb);
    frame_end();
    chk("pre_cnt", we_cnt - base, 3);
    chk("pre_wrap_addr", 32'(wa[6'(base + 2)]), 'h0);

    // Read 03 0E + 3 dummies -> 81 7E FF
    base = we_cnt;
    frame_start();
    spi_bits(8'h03, 8, rxb);
    spi_bits(8'h0E, 8, rxb);
    spi_bits(8'h00, 8, rxb);
    chk("rd0", 32'(rxb), 'h81);
    spi_bits(8'h00, 8, rxb);
    chk("rd1", 32'(rxb), 'h7E);
    spi_bits(8'h00, 8, rxb);
    chk("rd2_wrap", 32'(rxb), 'hFF);
    frame_end();
    chk("rd_no_we", we_cnt - base, 0);
    chk("rd_miso_idle", 32'(spi_miso), 0);

    // Abort a partial data byte, then a normal write
    base = we_cnt;
    frame_start();
    spi_bits(8'h02, 8, rxb);
    spi_bits(8'h03, 8, rxb);
    spi_bits(8'hC0, 4, rxb);
    frame_end();
    chk("abort_no_we", we_cnt - base, 0);
    frame_start();
    spi_bits(8'h02, 8, rxb);
    spi_bits(8'h03, 8, rxb);
    spi_bits(8'h11, 8, rxb);
    frame_end();
    chk("abort_next_cnt", we_cnt - base, 1);
    chk("abort_next_addr", 32'(wa[6'(base)]), 'h3);
    chk("abort_next_data", 32'(wd[6'(base)]), 'h11);

    // Unknown command
    base = we_cnt;
    frame_start();
    spi_bits(8'h55, 8, rxb);
    chk("unk_miso0", 32'(rxb), 0);
    spi_bits(8'hAA, 8, rxb);
    chk("unk_miso1", 32'(rxb), 0);
    spi_bits(8'h0F, 8, rxb);
    chk("unk_miso2", 32'(rxb), 0);
    chk("unk_busy", 32'(busy), 1);
    frame_end();
    chk("unk_no_we", we_cnt - base, 0);
    chk("unk_busy_end", 32'(busy), 0);

    // Reset in the middle of a read frame
    frame_start();
    spi_bits(8'h03, 8, rxb);
    spi_bits(8'h0E, 8, rxb);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_miso_pre", 32'(spi_miso), 1);
    chk("mid_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_miso", 32'(spi_miso), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_we", 32'(mem_we), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    spi_cs = 1'b1;
    repeat (4) @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    base = we_cnt;
    frame_start();
    spi_bits(8'h02, 8, rxb);
    spi_bits(8'h07, 8, rxb);
    spi_bits(8'h5A, 8, rxb);
    frame_end();
    chk("post_rst_cnt", we_cnt - base, 1);
    chk("post_rst_addr", 32'(wa[6'(base)]), 'h7);
    chk("post_rst_data", 32'(wd[6'(base)]), 'h5A);

    // 16-byte burst write then read-back, random frame phase
    for (int i = 0; i < 16; i++) pat[i] = 8'($urandom_range(0, 255));
    base = we_cnt;
    frame_start();
    spi_bits(8'h02, 8, rxb);
    spi_bits(8'h00, 8, rxb);
    for (int i = 0; i < 16; i++) spi_bits(pat[i], 8, rxb);
    frame_end();
    chk("burst_cnt", we_cnt - base, 16);
    chk("burst_last_addr", 32'(wa[6'(base + 15)]), 'hF);
    frame_start();
    spi_bits(8'h03, 8, rxb);
    spi_bits(8'h00, 8, rxb);
    for (int i = 0; i < 16; i++) begin
      spi_bits(8'h00, 8, rxb);
      chk($sformatf("burst_rd%0d", i), 32'(rxb), 32'(pat[i]));
    end
    frame_end();
    chk("burst_busy_end", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
